// File: rtl/resp_pool_pkg.sv
// Shared definitions for the pooled response store: flush FSM states and width helpers.
package resp_pool_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } flush_state_e;

  // Pointer width for a pool of the given depth (at least one bit).
  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Counter width able to hold 0..max_beats inclusive.
  function automatic int cnt_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

  localparam int PTR_W = ptr_width(32);
  localparam int CNT_W = cnt_width(16);

endpackage

// File: rtl/r_if.sv
// AXI-style R channel bundle with sender/receiver views.
interface r_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2
);
  logic                  valid;
  logic                  ready;
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [RESP_WIDTH-1:0] resp;
  logic                  last;

  modport sender   (output valid, id, data, resp, last, input ready);
  modport receiver (input valid, id, data, resp, last, output ready);
endinterface

// File: rtl/pool_free_list.sv
// Circular FIFO of unallocated pool indices, filled with 0..DEPTH-1 at reset.
module pool_free_list #(
  parameter int DEPTH = 32,
  parameter int IDX_W = 5,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             rel,
  input  logic [IDX_W-1:0] rel_idx,
  output logic [CNT_W-1:0] count
);

  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH - 1);

  logic [IDX_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0] rd_ptr;
  logic [IDX_W-1:0] wr_ptr;

  function automatic logic [IDX_W-1:0] bump(input logic [IDX_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + IDX_W'(1);
  endfunction

  assign alloc_idx = mem[rd_ptr];

  // Pointer/count bookkeeping; a released index lands behind the read pointer so it
  // cannot be handed out in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= IDX_W'(i);
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= CNT_W'(DEPTH);
    end else begin
      if (alloc) rd_ptr <= bump(rd_ptr);
      if (rel) begin
        mem[wr_ptr] <= rel_idx;
        wr_ptr      <= bump(wr_ptr);
      end
      if (alloc && !rel) count <= count - CNT_W'(1);
      else if (rel && !alloc) count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/response_pool_memory.sv
// Pooled R-beat store: per-UID linked-list queues over one shared entry pool,
// with occupancy cap, complete-burst bitmap and a multi-cycle per-UID flush.
module response_pool_memory
  import resp_pool_pkg::*;
#(
  parameter int NUM_UIDS          = 16,
  parameter int ID_WIDTH          = 4,
  parameter int POOL_DEPTH        = 32,
  parameter int MAX_BEATS_PER_UID = 16,
  parameter int DATA_WIDTH        = 64,
  parameter int RESP_WIDTH        = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  r_if.receiver                           r_in,
  r_if.sender                             r_out,
  input  logic [ID_WIDTH-1:0]             uid_to_free,
  input  logic                            free_req,
  output logic                            free_ack,
  input  logic                            flush_req,
  input  logic [ID_WIDTH-1:0]             uid_to_flush,
  output logic                            flush_busy,
  output logic                            flush_done,
  output logic [NUM_UIDS-1:0]             uid_has_last,
  output logic [$clog2(POOL_DEPTH+1)-1:0] free_count
);

  localparam int PW = ptr_width(POOL_DEPTH);
  localparam int CW = cnt_width(MAX_BEATS_PER_UID);
  localparam int FW = $clog2(POOL_DEPTH + 1);
  localparam logic [CW-1:0] CAP = CW'(MAX_BEATS_PER_UID);

  logic [DATA_WIDTH-1:0] pool_data [POOL_DEPTH];
  logic [RESP_WIDTH-1:0] pool_resp [POOL_DEPTH];
  logic                  pool_last [POOL_DEPTH];
  logic [PW-1:0]         pool_next [POOL_DEPTH];

  logic [PW-1:0] head     [NUM_UIDS];
  logic [PW-1:0] tail     [NUM_UIDS];
  logic [CW-1:0] cnt      [NUM_UIDS];
  logic [CW-1:0] last_cnt [NUM_UIDS];

  flush_state_e        state;
  logic [ID_WIDTH-1:0] flush_uid;

  logic                push, pop, walk, rel, rel_last;
  logic [PW-1:0]       alloc_idx, rel_idx, rd_idx;
  logic [ID_WIDTH-1:0] rel_uid;
  logic [NUM_UIDS-1:0] push_vec, rel_vec;
  logic                push_hit, pop_hit, flush_empty;

  assign r_in.ready = (free_count != FW'(0)) && (cnt[r_in.id] < CAP) &&
                      !(flush_busy && (r_in.id == flush_uid));
  assign push = r_in.valid && r_in.ready;

  assign rd_idx      = head[uid_to_free];
  assign r_out.valid = free_req && (cnt[uid_to_free] != CW'(0)) && !flush_busy;
  assign r_out.id    = uid_to_free;
  assign r_out.data  = r_out.valid ? pool_data[rd_idx] : '0;
  assign r_out.resp  = r_out.valid ? pool_resp[rd_idx] : '0;
  assign r_out.last  = r_out.valid ? pool_last[rd_idx] : 1'b0;
  assign pop         = r_out.valid && r_out.ready;
  assign free_ack    = pop;

  // Pops are blocked during a flush, so at most one of pop/walk releases an entry.
  assign walk     = (state == WALK);
  assign rel      = pop || walk;
  assign rel_uid  = walk ? flush_uid : uid_to_free;
  assign rel_idx  = head[rel_uid];
  assign rel_last = pool_last[rel_idx];

  // The flush decision looks at the count as it will be after this cycle's push/pop.
  assign push_hit    = push && (r_in.id == uid_to_flush);
  assign pop_hit     = pop && (uid_to_free == uid_to_flush);
  assign flush_empty = !push_hit && ((cnt[uid_to_flush] == CW'(0)) ||
                                     ((cnt[uid_to_flush] == CW'(1)) && pop_hit));

  pool_free_list #(.DEPTH(POOL_DEPTH), .IDX_W(PW), .CNT_W(FW)) u_free_list (
    .clk      (clk),
    .rst_n    (rst_n),
    .alloc    (push),
    .alloc_idx(alloc_idx),
    .rel      (rel),
    .rel_idx  (rel_idx),
    .count    (free_count)
  );

  // One-hot per-UID push/release strobes.
  always_comb begin
    push_vec = '0;
    rel_vec  = '0;
    if (push) push_vec[r_in.id] = 1'b1;
    if (rel)  rel_vec[rel_uid]  = 1'b1;
  end

  // Complete-burst bitmap.
  always_comb begin
    uid_has_last = '0;
    for (int u = 0; u < NUM_UIDS; u++) uid_has_last[u] = (last_cnt[u] != CW'(0));
  end

  // Pool payload and link storage; contents are meaningless until linked into a queue.
  always_ff @(posedge clk) begin
    if (push) begin
      pool_data[alloc_idx] <= r_in.data;
      pool_resp[alloc_idx] <= r_in.resp;
      pool_last[alloc_idx] <= r_in.last;
      if (cnt[r_in.id] != CW'(0)) pool_next[tail[r_in.id]] <= alloc_idx;
    end
  end

  // Per-UID queue pointers and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < NUM_UIDS; u++) begin
        head[u]     <= '0;
        tail[u]     <= '0;
        cnt[u]      <= '0;
        last_cnt[u] <= '0;
      end
    end else begin
      for (int u = 0; u < NUM_UIDS; u++) begin
        if (push_vec[u] && !rel_vec[u]) cnt[u] <= cnt[u] + CW'(1);
        else if (rel_vec[u] && !push_vec[u]) cnt[u] <= cnt[u] - CW'(1);

        if ((push_vec[u] && r_in.last) && !(rel_vec[u] && rel_last))
          last_cnt[u] <= last_cnt[u] + CW'(1);
        else if ((rel_vec[u] && rel_last) && !(push_vec[u] && r_in.last))
          last_cnt[u] <= last_cnt[u] - CW'(1);

        if (push_vec[u]) tail[u] <= alloc_idx;

        // Pushing into an empty queue, or one being drained of its only beat,
        // makes the new entry the head.
        if (push_vec[u] && ((cnt[u] == CW'(0)) || (rel_vec[u] && (cnt[u] == CW'(1)))))
          head[u] <= alloc_idx;
        else if (rel_vec[u])
          head[u] <= pool_next[head[u]];
      end
    end
  end

  // Flush sequencer with registered busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      flush_uid  <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_req) begin
            flush_uid  <= uid_to_flush;
            flush_busy <= 1'b1;
            if (flush_empty) begin
              state      <= DONE;
              flush_done <= 1'b1;
            end else begin
              state <= WALK;
            end
          end
        end
        WALK: begin
          if (cnt[flush_uid] == CW'(1)) begin
            state      <= DONE;
            flush_done <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          flush_busy <= 1'b0;
          flush_done <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          flush_busy <= 1'b0;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_response_pool_memory.sv
// Bench for response_pool_memory: directed scenarios plus random traffic, checked
// every cycle against per-UID beat queues held in the bench.
module tb_response_pool_memory;

  localparam int NU = 16;
  localparam int IW = 4;
  localparam int PD = 32;
  localparam int MB = 16;
  localparam int DW = 64;
  localparam int RW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  r_if #(.ID_WIDTH(IW), .DATA_WIDTH(DW), .RESP_WIDTH(RW)) rin ();
  r_if #(.ID_WIDTH(IW), .DATA_WIDTH(DW), .RESP_WIDTH(RW)) rout ();

  logic [IW-1:0] uid_to_free, uid_to_flush;
  logic          free_req, free_ack, flush_req, flush_busy, flush_done;
  logic [NU-1:0] uid_has_last;
  logic [5:0]    free_count;

  response_pool_memory #(
    .NUM_UIDS(NU), .ID_WIDTH(IW), .POOL_DEPTH(PD),
    .MAX_BEATS_PER_UID(MB), .DATA_WIDTH(DW), .RESP_WIDTH(RW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .r_in        (rin),
    .r_out       (rout),
    .uid_to_free (uid_to_free),
    .free_req    (free_req),
    .free_ack    (free_ack),
    .flush_req   (flush_req),
    .uid_to_flush(uid_to_flush),
    .flush_busy  (flush_busy),
    .flush_done  (flush_done),
    .uid_has_last(uid_has_last),
    .free_count  (free_count)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [RW-1:0] resp;
    logic          last;
  } beat_t;

  // Reference: one FIFO of beats per UID; flush is "k more walk cycles, then done".
  beat_t mq [NU][$];
  bit    fbusy;
  int    fwalk;
  int    fuid;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int qtotal();
    int s = 0;
    for (int u = 0; u < NU; u++) s += mq[u].size();
    return s;
  endfunction

  task automatic model_clear();
    for (int u = 0; u < NU; u++) mq[u].delete();
    fbusy = 0;
    fwalk = 0;
    fuid  = 0;
  endtask

  task automatic idle_in();
    rin.valid    = 1'b0;
    rin.id       = '0;
    rin.data     = '0;
    rin.resp     = '0;
    rin.last     = 1'b0;
    free_req     = 1'b0;
    uid_to_free  = '0;
    rout.ready   = 1'b0;
    flush_req    = 1'b0;
    uid_to_flush = '0;
  endtask

  task automatic drive_push(input int id, input logic last);
    rin.valid = 1'b1;
    rin.id    = IW'(id);
    rin.data  = {$urandom(), $urandom()};
    rin.resp  = RW'($urandom_range(0, 3));
    rin.last  = last;
  endtask

  task automatic drive_pop(input int u);
    free_req    = 1'b1;
    uid_to_free = IW'(u);
    rout.ready  = 1'b1;
  endtask

  // Called at a falling edge with inputs driven: check, clock, update reference.
  task automatic tick();
    bit            e_ready, e_valid, e_done;
    beat_t         e_beat;
    logic [NU-1:0] e_hl;
    int            id, fu;
    #1;
    id      = int'(rin.id);
    fu      = int'(uid_to_free);
    e_ready = (qtotal() < PD) && (mq[id].size() < MB) && !(fbusy && id == fuid);
    e_valid = free_req && (mq[fu].size() > 0) && !fbusy;
    e_beat  = e_valid ? mq[fu][0] : '0;
    e_done  = fbusy && (fwalk == 0);
    e_hl    = '0;
    for (int u = 0; u < NU; u++)
      foreach (mq[u][k]) if (mq[u][k].last) e_hl[u] = 1'b1;

    chk("in_ready", rin.ready, e_ready);
    chk("out_valid", rout.valid, e_valid);
    chk("out_beat", {rout.data, rout.resp, rout.last}, e_beat);
    if (e_valid) chk("out_id", rout.id, fu);
    chk("free_ack", free_ack, e_valid && rout.ready);
    chk("flush_busy", flush_busy, fbusy);
    chk("flush_done", flush_done, e_done);
    chk("uid_has_last", uid_has_last, e_hl);
    chk("free_count", free_count, PD - qtotal());

    @(posedge clk);
    if (e_valid && rout.ready) void'(mq[fu].pop_front());
    if (rin.valid && e_ready) mq[id].push_back({rin.data, rin.resp, rin.last});
    if (!fbusy) begin
      if (flush_req) begin
        fbusy = 1;
        fuid  = int'(uid_to_flush);
        fwalk = mq[fuid].size();
      end
    end else if (fwalk > 0) begin
      void'(mq[fuid].pop_front());
      fwalk--;
    end else begin
      fbusy = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_push(input int id, input logic last);
    idle_in();
    drive_push(id, last);
    tick();
  endtask

  task automatic do_pop(input int u);
    idle_in();
    drive_pop(u);
    tick();
  endtask

  task automatic drain_all();
    for (int u = 0; u < NU; u++)
      for (int k = 0; k < 2 * MB && mq[u].size() > 0; k++) do_pop(u);
    idle_in();
    tick();
  endtask

  initial begin
    int nb, nd;
    model_clear();
    idle_in();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_free_count", free_count, PD);
    chk("rst_in_ready", rin.ready, 1'b1);
    chk("rst_out_valid", rout.valid, 1'b0);
    chk("rst_busy_done", {flush_busy, flush_done, free_ack}, 3'b000);
    chk("rst_has_last", uid_has_last, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Four beats on UID 3, burst end on the fourth, then pop them all.
    for (int i = 0; i < 4; i++) do_push(3, i == 3);
    chk("uid3_free_count_28", free_count, 28);
    for (int i = 0; i < 4; i++) do_pop(3);
    chk("uid3_has_last_clear", uid_has_last[3], 1'b0);

    // Interleaved UIDs 1/2, UID 2 drained first.
    for (int i = 0; i < 3; i++) begin
      do_push(1, i == 2);
      do_push(2, i == 2);
    end
    for (int i = 0; i < 3; i++) do_pop(2);
    for (int i = 0; i < 3; i++) do_pop(1);

    // Fill the whole pool across UIDs 0/5, probe full, free one, refill.
    for (int i = 0; i < PD; i++) do_push((i % 2 == 1) ? 5 : 0, i % 4 == 3);
    chk("pool_full_count", free_count, 0);
    do_push(6, 1'b0);
    do_pop(0);
    do_push(6, 1'b1);
    drain_all();

    // Per-UID cap on UID 7 while UID 8 still flows.
    for (int i = 0; i < MB; i++) do_push(7, 1'b0);
    do_push(7, 1'b1);
    do_push(8, 1'b1);
    drain_all();

    // Flush UID 4 holding five beats, with UID 4 writes pending throughout.
    for (int i = 0; i < 5; i++) do_push(4, i == 4);
    idle_in();
    flush_req    = 1'b1;
    uid_to_flush = IW'(4);
    tick();
    nb = 0;
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      nb += int'(flush_busy);
      nd += int'(flush_done);
      idle_in();
      drive_push(4, 1'b0);
      tick();
    end
    chk("flush_busy_cycles", nb, 6);
    chk("flush_done_pulses", nd, 1);
    drain_all();

    // Flush of an empty UID.
    idle_in();
    flush_req    = 1'b1;
    uid_to_flush = IW'(11);
    tick();
    idle_in();
    tick();
    tick();

    // Same-cycle push and pop on a single-beat UID 9.
    do_push(9, 1'b0);
    idle_in();
    drive_push(9, 1'b1);
    drive_pop(9);
    tick();
    chk("uid9_one_left", free_count, PD - 1);
    do_pop(9);
    idle_in();
    tick();

    // Random traffic over a few hot UIDs plus occasional others.
    for (int c = 0; c < 3000; c++) begin
      idle_in();
      if ($urandom_range(0, 99) < 60)
        drive_push(($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(0, NU - 1),
                   $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) < ((c < 1500) ? 35 : 75)) begin
        free_req    = 1'b1;
        uid_to_free = IW'($urandom_range(0, 3));
      end
      rout.ready = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 39) == 0) begin
        flush_req    = 1'b1;
        uid_to_flush = IW'($urandom_range(0, 3));
      end
      tick();
    end
    idle_in();
    for (int c = 0; c < 40 && fbusy; c++) tick();
    drain_all();

    // Asynchronous reset in the middle of a flush.
    for (int i = 0; i < 3; i++) do_push(2, i == 2);
    do_push(6, 1'b1);
    idle_in();
    flush_req    = 1'b1;
    uid_to_flush = IW'(2);
    tick();
    idle_in();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_free_count", free_count, PD);
    chk("async_rst_busy", flush_busy, 1'b0);
    chk("async_rst_has_last", uid_has_last, '0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_push(2, 1'b1);
    do_pop(2);
    idle_in();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
